// File: rtl/eth_mmio_pkg.sv
// rtl/eth_mmio_pkg.sv - shared constants, state type and keep helper for the Ethernet RX MMIO reader
package eth_mmio_pkg;

    localparam logic [13:0] ETH_RX_BUF_BASE = 14'h0000;
    localparam logic [13:0] ETH_RX_SLOT     = 14'h1000;
    localparam logic [13:0] ETH_RX_LEN      = 14'h1004;
    localparam logic [13:0] ETH_RX_PEND     = 14'h1010;
    localparam logic [13:0] ETH_RX_EN       = 14'h1014;
    localparam logic [13:0] ETH_TX_START    = 14'h1018;
    localparam logic [13:0] ETH_TX_READY    = 14'h101C;
    localparam logic [13:0] ETH_TX_LEN      = 14'h1028;
    localparam logic [13:0] ETH_TX_PEND     = 14'h1030;

    // Every access is a full 32-bit word: log2(4 bytes).
    localparam logic [1:0] ETH_OP_SIZE_WORD = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL,
        ST_POLL_WAIT,
        ST_LEN,
        ST_LEN_WAIT,
        ST_RD,
        ST_RD_WAIT,
        ST_OUT,
        ST_ACK
    } eth_rx_state_e;

    // Byte mask of the final word given the two low bits of the packet length.
    function automatic logic [3:0] last_word_keep(input logic [1:0] tail);
        return (tail == 2'd0) ? 4'hF : ((4'h1 << tail) - 4'h1);
    endfunction

endpackage

// File: rtl/eth_poll_timer.sv
// rtl/eth_poll_timer.sv - idle counter producing a terminal-count pulse every interval_p enabled cycles
module eth_poll_timer #(
    parameter int interval_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic clear_i,
    output logic tc_o
);

    localparam int cnt_w_lp = $clog2(interval_p + 1);
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(interval_p - 1);

    logic [cnt_w_lp-1:0] count_q;

    assign tc_o = en_i && !clear_i && (count_q == last_lp);

    // Count enabled cycles; restart on clear or when the interval elapses, hold while disabled.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (clear_i || tc_o) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/ethernet_rx_mmio_reader.sv
// rtl/ethernet_rx_mmio_reader.sv - MMIO initiator that drains RX packets from the Ethernet control unit onto a stream
module ethernet_rx_mmio_reader
    import eth_mmio_pkg::*;
#(
    parameter int eth_mtu_p       = 2048,
    parameter int data_width_p    = 32,
    parameter int poll_interval_p = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    output logic [13:0]             addr_o,
    output logic                    read_en_o,
    output logic                    write_en_o,
    output logic [1:0]              op_size_o,
    output logic [data_width_p-1:0] write_data_o,
    input  logic [data_width_p-1:0] read_data_i,
    input  logic                    io_decode_error_i,
    output logic [data_width_p-1:0] data_o,
    output logic [3:0]              keep_o,
    output logic                    last_o,
    output logic                    v_o,
    input  logic                    ready_i,
    output logic [11:0]             pkt_len_o,
    output logic                    oversize_o,
    output logic                    error_o,
    output logic                    busy_o
);

    eth_rx_state_e state_q, state_d;

    logic [8:0]              word_idx_q;
    logic [11:0]             len_q;
    logic [data_width_p-1:0] data_q;
    logic                    oversize_q;
    logic                    error_q;
    logic                    poll_tc;
    logic                    decode_err;
    logic                    handshake;
    logic                    last_word;
    logic                    len_oversize;
    logic [12:0]             words_m1;

    eth_poll_timer #(
        .interval_p (poll_interval_p)
    ) u_poll_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (en_i),
        .clear_i   (state_q != ST_IDLE),
        .tc_o      (poll_tc)
    );

    // Index of the final word: ceil(len/4)-1, computed wide so a 2048-byte packet never wraps.
    assign words_m1     = ((13'(len_q) + 13'd3) >> 2) - 13'd1;
    assign last_word    = ({4'd0, word_idx_q} == words_m1);
    assign decode_err   = io_decode_error_i && (read_en_o || write_en_o);
    assign handshake    = (state_q == ST_OUT) && ready_i;
    assign len_oversize = ({1'b0, read_data_i[11:0]} > 13'(eth_mtu_p));

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a decode error on any strobe abandons the packet without an ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (poll_tc) state_d = ST_POLL;
            ST_POLL:      state_d = decode_err ? ST_IDLE : ST_POLL_WAIT;
            ST_POLL_WAIT: state_d = read_data_i[0] ? ST_LEN : ST_IDLE;
            ST_LEN:       state_d = decode_err ? ST_IDLE : ST_LEN_WAIT;
            ST_LEN_WAIT: begin
                if (read_data_i[11:0] == 12'd0 || len_oversize) state_d = ST_ACK;
                else                                            state_d = ST_RD;
            end
            ST_RD:        state_d = decode_err ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT:   state_d = ST_OUT;
            ST_OUT:       if (handshake) state_d = last_word ? ST_ACK : ST_RD;
            ST_ACK:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Packet datapath: length, word index, captured word and sticky status flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            word_idx_q <= '0;
            len_q      <= '0;
            data_q     <= '0;
            oversize_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (state_q == ST_LEN_WAIT) begin
                len_q      <= read_data_i[11:0];
                word_idx_q <= '0;
                if (len_oversize) oversize_q <= 1'b1;
            end
            if (state_q == ST_RD_WAIT) data_q <= read_data_i;
            if (handshake && !last_word) word_idx_q <= word_idx_q + 9'd1;
            if (decode_err) error_q <= 1'b1;
        end
    end

    // Output decode: strobes and address follow the state, stream qualifiers only in OUT.
    always_comb begin
        read_en_o    = 1'b0;
        write_en_o   = 1'b0;
        addr_o       = 14'h0000;
        write_data_o = '0;
        v_o          = 1'b0;
        keep_o       = 4'h0;
        last_o       = 1'b0;
        case (state_q)
            ST_POLL: begin
                read_en_o = 1'b1;
                addr_o    = ETH_RX_PEND;
            end
            ST_LEN: begin
                read_en_o = 1'b1;
                addr_o    = ETH_RX_LEN;
            end
            ST_RD: begin
                read_en_o = 1'b1;
                addr_o    = ETH_RX_BUF_BASE + {3'b000, word_idx_q, 2'b00};
            end
            ST_OUT: begin
                v_o    = 1'b1;
                last_o = last_word;
                keep_o = last_word ? last_word_keep(len_q[1:0]) : 4'hF;
            end
            ST_ACK: begin
                write_en_o   = 1'b1;
                addr_o       = ETH_RX_PEND;
                write_data_o = data_width_p'(1);
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign op_size_o  = ETH_OP_SIZE_WORD;
    assign data_o     = data_q;
    assign pkt_len_o  = len_q;
    assign oversize_o = oversize_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_ethernet_rx_mmio_reader.sv
// tb/tb_ethernet_rx_mmio_reader.sv - scoreboard bench for the Ethernet RX MMIO reader
module tb_ethernet_rx_mmio_reader;

    localparam int POLL_N = 16;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        en_i;
    logic [13:0] addr_o;
    logic        read_en_o;
    logic        write_en_o;
    logic [1:0]  op_size_o;
    logic [31:0] write_data_o;
    logic [31:0] read_data_i;
    logic        io_decode_error_i;
    logic [31:0] data_o;
    logic [3:0]  keep_o;
    logic        last_o;
    logic        v_o;
    logic        ready_i;
    logic [11:0] pkt_len_o;
    logic        oversize_o;
    logic        error_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    ethernet_rx_mmio_reader #(
        .eth_mtu_p       (2048),
        .data_width_p    (32),
        .poll_interval_p (POLL_N)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .en_i              (en_i),
        .addr_o            (addr_o),
        .read_en_o         (read_en_o),
        .write_en_o        (write_en_o),
        .op_size_o         (op_size_o),
        .write_data_o      (write_data_o),
        .read_data_i       (read_data_i),
        .io_decode_error_i (io_decode_error_i),
        .data_o            (data_o),
        .keep_o            (keep_o),
        .last_o            (last_o),
        .v_o               (v_o),
        .ready_i           (ready_i),
        .pkt_len_o         (pkt_len_o),
        .oversize_o        (oversize_o),
        .error_o           (error_o),
        .busy_o            (busy_o)
    );

    typedef struct {
        bit          wr;
        logic [13:0] addr;
        logic [31:0] data;
        int          gap;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [11:0] len;
    } beat_t;

    acc_t  exp_acc[$];
    beat_t exp_beat[$];

    int checks = 0;
    int errors = 0;
    int cyc;
    int last_cyc;

    logic        pend;
    logic [31:0] len_val;
    logic [31:0] mem [0:511];
    logic        err_arm;
    logic [13:0] err_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_acc(input bit wr, input logic [13:0] addr, input logic [31:0] data, input int gap);
        acc_t a;
        a.wr = wr; a.addr = addr; a.data = data; a.gap = gap;
        exp_acc.push_back(a);
    endtask

    task automatic push_beat(input logic [31:0] data, input logic [3:0] keep, input logic last, input logic [11:0] len);
        beat_t b;
        b.data = data; b.keep = keep; b.last = last; b.len = len;
        exp_beat.push_back(b);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while ((exp_acc.size() != 0 || exp_beat.size() != 0 || busy_o) && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int n = 0;
        while (!v_o && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 32'(v_o), 32'd1);
    endtask

    // Cycle stamp: number of clock edges since reset release.
    always @(posedge clk_i) begin
        if (!reset_n_i) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // MMIO responder: read data for the cycle after the strobe, decode error alongside the strobe.
    always @(negedge clk_i) begin
        io_decode_error_i = err_arm && (read_en_o || write_en_o) && (addr_o == err_addr);
        if (read_en_o) begin
            if (addr_o == 14'h1010)      read_data_i = {31'd0, pend};
            else if (addr_o == 14'h1004) read_data_i = len_val;
            else if (addr_o < 14'h0800)  read_data_i = mem[addr_o[10:2]];
            else                         read_data_i = 32'hDEAD_BEEF;
        end
    end

    // Access scoreboard: order, address, write data, spacing and strobe exclusivity.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            last_cyc = 0;
        end else if (read_en_o || write_en_o) begin
            acc_t e;
            chk("strobe_exclusive", 32'(read_en_o && write_en_o), 32'd0);
            chk("op_size", 32'(op_size_o), 32'd2);
            checks++;
            assert (exp_acc.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_access: observed wr=%0b addr=%h expected none", write_en_o, addr_o);
            end
            if (exp_acc.size() > 0) begin
                e = exp_acc.pop_front();
                chk("acc_kind", 32'(write_en_o), 32'(e.wr));
                chk("acc_addr", 32'(addr_o), 32'(e.addr));
                if (e.wr) chk("acc_wdata", write_data_o, e.data);
                if (e.gap >= 0) chk("acc_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
        end
    end

    // Stream scoreboard: each handshake is checked against the next expected beat.
    always @(negedge clk_i) begin
        if (reset_n_i && v_o && ready_i) begin
            beat_t b;
            checks++;
            assert (exp_beat.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat: observed data=%h expected none", data_o);
            end
            if (exp_beat.size() > 0) begin
                b = exp_beat.pop_front();
                chk("beat_data", data_o, b.data);
                chk("beat_keep", 32'(keep_o), 32'(b.keep));
                chk("beat_last", 32'(last_o), 32'(b.last));
                chk("beat_len", 32'(pkt_len_o), 32'(b.len));
            end
        end
    end

    initial begin
        reset_n_i = 1'b0;
        en_i      = 1'b1;
        ready_i   = 1'b1;
        pend      = 1'b0;
        len_val   = 32'd0;
        err_arm   = 1'b0;
        err_addr  = 14'h0000;
        read_data_i = 32'd0;
        io_decode_error_i = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

        // Reset state.
        tick(); tick(); tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_v", 32'(v_o), 32'd0);
        chk("rst_rd", 32'(read_en_o), 32'd0);
        chk("rst_wr", 32'(write_en_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_wdata", write_data_o, 32'd0);
        chk("rst_opsize", 32'(op_size_o), 32'd2);
        chk("rst_data", data_o, 32'd0);
        chk("rst_keep", 32'(keep_o), 32'd0);
        chk("rst_flags", 32'({last_o, oversize_o, error_o}), 32'd0);
        chk("rst_len", 32'(pkt_len_o), 32'd0);

        // 1: three empty polls, first one POLL_N cycles after release, then POLL_N+2 apart.
        push_acc(0, 14'h1010, 0, POLL_N);
        push_acc(0, 14'h1010, 0, POLL_N + 2);
        push_acc(0, 14'h1010, 0, POLL_N + 2);
        reset_n_i = 1'b1;
        wait_done("s1_polls", 200);
        en_i = 1'b0;
        repeat (40) tick();
        chk("s1_idle", 32'(busy_o), 32'd0);

        // 2: six-byte packet with the stream always ready.
        pend = 1'b1; len_val = 32'd6;
        mem[0] = 32'h1122_3344; mem[1] = 32'h5566_7788;
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(0, 14'h0000, 0, 2);
        push_acc(0, 14'h0004, 0, 3);
        push_acc(1, 14'h1010, 1, 3);
        push_beat(32'h1122_3344, 4'hF, 1'b0, 12'd6);
        push_beat(32'h5566_7788, 4'h3, 1'b1, 12'd6);
        en_i = 1'b1;
        wait_done("s2_done", 400);
        en_i = 1'b0; pend = 1'b0;

        // 3: same packet, consumer stalls five cycles on the first word.
        ready_i = 1'b0; pend = 1'b1;
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(0, 14'h0000, 0, 2);
        push_acc(0, 14'h0004, 0, -1);
        push_acc(1, 14'h1010, 1, 3);
        push_beat(32'h1122_3344, 4'hF, 1'b0, 12'd6);
        push_beat(32'h5566_7788, 4'h3, 1'b1, 12'd6);
        en_i = 1'b1;
        wait_valid("s3_valid", 200);
        for (int i = 0; i < 5; i++) begin
            chk("s3_hold_v", 32'(v_o), 32'd1);
            chk("s3_hold_data", data_o, 32'h1122_3344);
            chk("s3_no_read", 32'(read_en_o), 32'd0);
            tick();
        end
        ready_i = 1'b1;
        wait_done("s3_done", 400);
        en_i = 1'b0; pend = 1'b0;

        // 4a: zero-length packet is acked straight after the length read.
        pend = 1'b1; len_val = 32'd0;
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(1, 14'h1010, 1, 2);
        en_i = 1'b1;
        wait_done("s4a_done", 400);
        en_i = 1'b0; pend = 1'b0;
        chk("s4a_oversize", 32'(oversize_o), 32'd0);

        // 4b: oversize packet is dropped and acked.
        pend = 1'b1; len_val = 32'd3000;
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(1, 14'h1010, 1, 2);
        en_i = 1'b1;
        wait_done("s4b_done", 400);
        en_i = 1'b0; pend = 1'b0;
        chk("s4b_oversize", 32'(oversize_o), 32'd1);

        // 5: decode error on the second buffer read, then a clean retry of the same packet.
        pend = 1'b1; len_val = 32'd8;
        mem[0] = 32'hA0B0_C0D0; mem[1] = 32'h0102_0304;
        err_arm = 1'b1; err_addr = 14'h0004;
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(0, 14'h0000, 0, 2);
        push_acc(0, 14'h0004, 0, 3);
        push_beat(32'hA0B0_C0D0, 4'hF, 1'b0, 12'd8);
        en_i = 1'b1;
        wait_done("s5_abort", 400);
        err_arm = 1'b0;
        chk("s5_error", 32'(error_o), 32'd1);
        chk("s5_idle", 32'(busy_o), 32'd0);
        chk("s5_v", 32'(v_o), 32'd0);
        chk("s5_oversize_sticky", 32'(oversize_o), 32'd1);
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(0, 14'h0000, 0, 2);
        push_acc(0, 14'h0004, 0, 3);
        push_acc(1, 14'h1010, 1, 3);
        push_beat(32'hA0B0_C0D0, 4'hF, 1'b0, 12'd8);
        push_beat(32'h0102_0304, 4'hF, 1'b1, 12'd8);
        wait_done("s5_retry", 400);
        en_i = 1'b0; pend = 1'b0;

        // 6: asynchronous reset while a word is waiting in OUT.
        ready_i = 1'b0; pend = 1'b1; len_val = 32'd6;
        mem[0] = 32'h1122_3344; mem[1] = 32'h5566_7788;
        push_acc(0, 14'h1010, 0, -1);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(0, 14'h0000, 0, 2);
        en_i = 1'b1;
        wait_valid("s6_valid", 200);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("s6_v", 32'(v_o), 32'd0);
        chk("s6_strobes", 32'({read_en_o, write_en_o}), 32'd0);
        chk("s6_busy", 32'(busy_o), 32'd0);
        chk("s6_data", data_o, 32'd0);
        chk("s6_error", 32'(error_o), 32'd0);
        chk("s6_oversize", 32'(oversize_o), 32'd0);
        chk("s6_len", 32'(pkt_len_o), 32'd0);
        push_acc(0, 14'h1010, 0, POLL_N);
        push_acc(0, 14'h1004, 0, 2);
        push_acc(0, 14'h0000, 0, 2);
        push_acc(0, 14'h0004, 0, 3);
        push_acc(1, 14'h1010, 1, 3);
        push_beat(32'h1122_3344, 4'hF, 1'b0, 12'd6);
        push_beat(32'h5566_7788, 4'h3, 1'b1, 12'd6);
        ready_i = 1'b1;
        tick(); tick();
        reset_n_i = 1'b1;
        wait_done("s6_done", 400);
        chk("s6_queues", 32'(exp_acc.size() + exp_beat.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
